// File: rtl/pea_fire_scheduler_pkg.sv
// rtl/pea_fire_scheduler_pkg.sv - shared modes, state encodings and helpers for the PEA fire scheduler
package pea_fire_scheduler_pkg;

    // CFDF modes presented to the actor and its enable module on next_instr
    localparam logic [1:0] SETUP_INSTR = 2'b00;
    localparam logic [1:0] INSTR       = 2'b01;
    localparam logic [1:0] OUTPUT      = 2'b10;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_EN = 3'd1,
        S_FIRE    = 3'd2,
        S_WAIT_FC = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } sched_state_t;

    // Ceiling log2 for sizing counters from a limit value
    function automatic int pea_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_fire_scheduler_if.sv
// rtl/pea_fire_scheduler_if.sv - control/handshake bundle between host, PEA actor and the fire scheduler
interface pea_fire_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_instr;
    logic             enable;
    logic             FC;
    logic             invoke;
    logic [1:0]       next_instr;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] fire_count;

    // Host / actor side: drives control and completion, observes the schedule
    modport master (
        output start, abort, num_instr, enable, FC,
        input  invoke, next_instr, busy, done, error, fire_count
    );

    // Scheduler side
    modport slave (
        input  start, abort, num_instr, enable, FC,
        output invoke, next_instr, busy, done, error, fire_count
    );
endinterface

// File: rtl/pea_fire_scheduler_wdog.sv
// rtl/pea_fire_scheduler_wdog.sv - WAIT_FC watchdog counter, present only with PEA_SCHED_WDOG_EN
`ifdef PEA_SCHED_WDOG_EN
module pea_sched_wdog #(
    parameter int W     = 16,
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);
    // r_cnt holds how many WAIT_FC cycles have already elapsed, so the
    // LIMIT-th waiting cycle is the one where r_cnt equals LIMIT-1.
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // Clear when the firing is issued, count each waiting cycle, saturate at the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = i_run && (r_cnt == LAST);
endmodule
`endif

// File: rtl/pea_fire_scheduler.sv
// rtl/pea_fire_scheduler.sv - batch firing sequencer for the PEA actor; watchdog option PEA_SCHED_WDOG_EN
module pea_fire_scheduler
    import pea_fire_scheduler_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    pea_fire_scheduler_if.slave  bus
);

    sched_state_t     r_state;
    logic             r_invoke;
    logic [1:0]       r_next_instr;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_fire_count;
    logic [CNT_W-1:0] r_num_instr;
    logic [CNT_W-1:0] r_pair_cnt;
    logic [CNT_W-1:0] w_pair_inc;

    assign w_pair_inc = r_pair_cnt + CNT_W'(1);

`ifdef PEA_SCHED_WDOG_EN
    logic r_error;
    logic w_wdog_expired;
    logic w_wdog_clear;
    logic w_wdog_run;

    // The firing cycle arms the watchdog so it counts from the first WAIT_FC cycle
    assign w_wdog_clear = (r_state == S_FIRE);
    assign w_wdog_run   = (r_state == S_WAIT_FC);

    pea_sched_wdog #(
        .W     (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wdog_clear),
        .i_run     (w_wdog_run),
        .o_expired (w_wdog_expired)
    );

    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

    // Scheduler FSM: state, mode sequencing, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_invoke     <= 1'b0;
            r_next_instr <= SETUP_INSTR;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fire_count <= '0;
            r_num_instr  <= '0;
            r_pair_cnt   <= '0;
`ifdef PEA_SCHED_WDOG_EN
            r_error      <= 1'b0;
`endif
        end else if (bus.abort && (r_state != S_IDLE)) begin
            // Abort wins over everything, including a coincident start or FC;
            // done and error keep their values so the host can still read them.
            r_state      <= S_IDLE;
            r_invoke     <= 1'b0;
            r_next_instr <= SETUP_INSTR;
            r_busy       <= 1'b0;
        end else begin
            r_invoke <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_num_instr  <= bus.num_instr;
                        r_pair_cnt   <= '0;
                        r_fire_count <= '0;
                        r_done       <= 1'b0;
                        r_next_instr <= SETUP_INSTR;
                        r_busy       <= 1'b1;
                        r_state      <= S_WAIT_EN;
`ifdef PEA_SCHED_WDOG_EN
                        r_error      <= 1'b0;
`endif
                    end
                end

                S_WAIT_EN: begin
                    if (bus.enable) begin
                        r_invoke <= 1'b1;
                        r_state  <= S_FIRE;
                    end
                end

                // FC is deliberately not looked at here; completion counts only from WAIT_FC
                S_FIRE: begin
                    r_state <= S_WAIT_FC;
                end

                S_WAIT_FC: begin
                    if (bus.FC) begin
                        r_fire_count <= r_fire_count + CNT_W'(1);
                        r_state      <= S_ADVANCE;
                    end
`ifdef PEA_SCHED_WDOG_EN
                    else if (w_wdog_expired) begin
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end
`endif
                end

                S_ADVANCE: begin
                    case (r_next_instr)
                        SETUP_INSTR: begin
                            if (r_num_instr == '0) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_next_instr <= INSTR;
                                r_state      <= S_WAIT_EN;
                            end
                        end
                        INSTR: begin
                            r_next_instr <= OUTPUT;
                            r_state      <= S_WAIT_EN;
                        end
                        OUTPUT: begin
                            r_pair_cnt <= w_pair_inc;
                            if (w_pair_inc == r_num_instr) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_next_instr <= INSTR;
                                r_state      <= S_WAIT_EN;
                            end
                        end
                        default: begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    endcase
                end

                default: begin
                    r_busy       <= 1'b0;
                    r_next_instr <= SETUP_INSTR;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.invoke     = r_invoke;
    assign bus.next_instr = r_next_instr;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.fire_count = r_fire_count;

endmodule
